// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared hazard-controller types: FSM state encoding, ID source-field slots and id_use bit map.
// Latency: n/a (types, constants and a pure packing function only).
// Backpressure: n/a.
package vliw_pkg;

    localparam int REG_W      = 3;
    localparam int NUM_SRC    = 6;
    localparam int WAIT_CNT_W = 4;

    // id_use bit positions; the packed source vector uses the same slot order
    localparam int USE_RD_SW       = 0;
    localparam int USE_LW_SW_SEL   = 1;
    localparam int USE_ADD_SEL     = 2;
    localparam int USE_SUB_RM_SEL  = 3;
    localparam int USE_SUB_RN_SEL  = 4;
    localparam int USE_CMP_SHFT_RD = 5;

    // Encoding 2'd3 is deliberately left unnamed: it is illegal and recovers to ST_RUN
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hz_state_t;

    typedef logic [REG_W-1:0]                reg_idx_t;
    typedef logic [NUM_SRC-1:0][REG_W-1:0]   src_vec_t;

    // Place each ID source field in the slot matching its id_use bit
    function automatic src_vec_t pack_srcs(
        input reg_idx_t rd_sw,
        input reg_idx_t lw_sw_sel,
        input reg_idx_t add_sel,
        input reg_idx_t sub_rm_sel,
        input reg_idx_t sub_rn_sel,
        input reg_idx_t cmp_shft_rd
    );
        src_vec_t v;
        v[USE_RD_SW]       = rd_sw;
        v[USE_LW_SW_SEL]   = lw_sw_sel;
        v[USE_ADD_SEL]     = add_sel;
        v[USE_SUB_RM_SEL]  = sub_rm_sel;
        v[USE_SUB_RN_SEL]  = sub_rn_sel;
        v[USE_CMP_SHFT_RD] = cmp_shft_rd;
        return v;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the pipeline (master) and the hazard/stall controller (slave).
// Latency: none; wires only.
// Backpressure: controller drives PCwrite/IFIDwrite/EXMEM_hold back to the pipeline.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       id_rd_sw;
    logic [2:0]       id_lw_sw_sel;
    logic [2:0]       id_add_sel;
    logic [2:0]       id_sub_rm_sel;
    logic [2:0]       id_sub_rn_sel;
    logic [2:0]       id_cmp_shft_rd;
    logic [5:0]       id_use;
    logic             id_flagRead;
    logic             IDEX_memRead1;
    logic             IDEX_regWrite1;
    logic             IDEX_flagWrite1;
    logic [2:0]       IDEX_rd1;
    logic             dmem_req;
    logic             dmem_ready;
    logic             PCwrite;
    logic             IFIDwrite;
    logic             IDEX_flush;
    logic             EXMEM_hold;
    logic [1:0]       hz_state;
    logic [CNT_W-1:0] stall_count;
    logic             mem_timeout;

    modport master (
        output id_rd_sw, id_lw_sw_sel, id_add_sel, id_sub_rm_sel, id_sub_rn_sel,
               id_cmp_shft_rd, id_use, id_flagRead, IDEX_memRead1, IDEX_regWrite1,
               IDEX_flagWrite1, IDEX_rd1, dmem_req, dmem_ready,
        input  PCwrite, IFIDwrite, IDEX_flush, EXMEM_hold, hz_state, stall_count,
               mem_timeout
    );

    modport slave (
        input  id_rd_sw, id_lw_sw_sel, id_add_sel, id_sub_rm_sel, id_sub_rn_sel,
               id_cmp_shft_rd, id_use, id_flagRead, IDEX_memRead1, IDEX_regWrite1,
               IDEX_flagWrite1, IDEX_rd1, dmem_req, dmem_ready,
        output PCwrite, IFIDwrite, IDEX_flush, EXMEM_hold, hz_state, stall_count,
               mem_timeout
    );

endinterface

// File: rtl/hazard_stall_ctrl_hz_reg_match.sv
// Six-way compare of ID source registers against the EX slot-1 destination.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module hz_reg_match
    import vliw_pkg::*;
(
    input  src_vec_t            src_fields,
    input  logic [NUM_SRC-1:0]  id_use,
    input  reg_idx_t            IDEX_rd1,
    output logic                match
);

    // Any source that is actually read and names the in-flight destination is a match
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_use[i] && (src_fields[i] == IDEX_rd1)) begin
                match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use / flag bubbles and data-memory wait stalls.
// Latency: control outputs combinational from state+inputs; state and counters registered.
// Backpressure: PCwrite/IFIDwrite low freeze fetch; EXMEM_hold freezes the back end on memory waits.
module hazard_stall_ctrl
    import vliw_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    hazard_stall_ctrl_if.slave hz
);

    localparam logic [WAIT_CNT_W:0] WAIT_LIM = WAIT_MAX[WAIT_CNT_W:0];

    hz_state_t             state;
    hz_state_t             state_nxt;
    logic [CNT_W-1:0]      stall_cnt;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WAIT_CNT_W:0]   wait_nxt;
    logic                  timeout;
    logic                  reg_match;
    logic                  load_use;
    logic                  flag_hz;
    logic                  mem_stall;
    logic                  pc_write;
    logic                  ifid_write;
    logic                  idex_flush;
    logic                  exmem_hold;

    hz_reg_match u_reg_match (
        .src_fields (pack_srcs(hz.id_rd_sw, hz.id_lw_sw_sel, hz.id_add_sel,
                               hz.id_sub_rm_sel, hz.id_sub_rn_sel, hz.id_cmp_shft_rd)),
        .id_use     (hz.id_use),
        .IDEX_rd1   (hz.IDEX_rd1),
        .match      (reg_match)
    );

    assign load_use  = hz.IDEX_memRead1 & hz.IDEX_regWrite1 & reg_match;
    assign flag_hz   = hz.IDEX_flagWrite1 & hz.id_flagRead;
    assign mem_stall = hz.dmem_req & ~hz.dmem_ready;
    assign wait_nxt  = {1'b0, wait_cnt} + {{WAIT_CNT_W{1'b0}}, 1'b1};

    // Next state and stall controls; memory stall beats a load-use bubble, reset forces free-run
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        idex_flush = 1'b0;
        exmem_hold = 1'b0;
        state_nxt  = state;
        case (state)
            ST_RUN: begin
                if (mem_stall) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    exmem_hold = 1'b1;
                    state_nxt  = ST_MEM_WAIT;
                end else if (load_use || flag_hz) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    state_nxt  = ST_LU_STALL;
                end else begin
                    state_nxt  = ST_RUN;
                end
            end
            ST_LU_STALL: begin
                // Bubble already inserted; do not re-detect the same hazard
                state_nxt = mem_stall ? ST_MEM_WAIT : ST_RUN;
            end
            ST_MEM_WAIT: begin
                if (!hz.dmem_ready) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    exmem_hold = 1'b1;
                    state_nxt  = ST_MEM_WAIT;
                end else begin
                    state_nxt  = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
        if (!reset_n) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            idex_flush = 1'b0;
            exmem_hold = 1'b0;
        end
    end

    // State, saturating stall counter, memory-wait counter and sticky timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
            wait_cnt  <= '0;
            timeout   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!pc_write && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (state == ST_MEM_WAIT) begin
                if (wait_cnt != '1) begin
                    wait_cnt <= wait_nxt[WAIT_CNT_W-1:0];
                end
                if (wait_nxt >= WAIT_LIM) begin
                    timeout <= 1'b1;
                end
            end else if (state_nxt == ST_MEM_WAIT) begin
                wait_cnt <= '0;
            end
        end
    end

    assign hz.PCwrite     = pc_write;
    assign hz.IFIDwrite   = ifid_write;
    assign hz.IDEX_flush  = idex_flush;
    assign hz.EXMEM_hold  = exmem_hold;
    assign hz.hz_state    = state;
    assign hz.stall_count = stall_cnt;
    assign hz.mem_timeout = timeout;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Latency: model predicts combinational outputs each cycle and registered state one edge later.
// Backpressure: n/a.
module tb_hazard_stall_ctrl;

    localparam int WAIT_MAX = 2;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk;
    logic reset_n;

    int errors = 0;
    int checks = 0;

    // Behavioural model state: phase 0=running, 1=after bubble, 2=waiting on memory
    int m_phase, m_stalls, m_waited;
    int n_phase, n_stalls, n_waited;
    bit m_tout, n_tout;

    hazard_stall_ctrl_if #(.CNT_W(CNT_W)) hz_bus ();

    hazard_stall_ctrl #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz_bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle model check on the falling edge, then compute what the next edge must produce
    always @(negedge clk) begin : model_cmp
        int  src [6];
        bit  lu, fh, ms, stall, flush, hold;
        if (!reset_n) begin
            m_phase = 0; m_stalls = 0; m_waited = 0; m_tout = 0;
        end
        src[0] = int'(hz_bus.id_rd_sw);
        src[1] = int'(hz_bus.id_lw_sw_sel);
        src[2] = int'(hz_bus.id_add_sel);
        src[3] = int'(hz_bus.id_sub_rm_sel);
        src[4] = int'(hz_bus.id_sub_rn_sel);
        src[5] = int'(hz_bus.id_cmp_shft_rd);
        lu = 0;
        foreach (src[i])
            if (hz_bus.id_use[i] && src[i] == int'(hz_bus.IDEX_rd1) &&
                hz_bus.IDEX_memRead1 && hz_bus.IDEX_regWrite1)
                lu = 1;
        fh = hz_bus.IDEX_flagWrite1 && hz_bus.id_flagRead;
        ms = hz_bus.dmem_req && !hz_bus.dmem_ready;

        stall = (m_phase == 0 && (ms || lu || fh)) || (m_phase == 2 && !hz_bus.dmem_ready);
        flush = (m_phase == 0) && !ms && (lu || fh);
        hold  = (m_phase == 0 && ms) || (m_phase == 2 && !hz_bus.dmem_ready);
        if (!reset_n) begin
            stall = 0; flush = 0; hold = 0;
        end

        chk("PCwrite",     int'(hz_bus.PCwrite),     int'(!stall));
        chk("IFIDwrite",   int'(hz_bus.IFIDwrite),   int'(!stall));
        chk("IDEX_flush",  int'(hz_bus.IDEX_flush),  int'(flush));
        chk("EXMEM_hold",  int'(hz_bus.EXMEM_hold),  int'(hold));
        chk("hz_state",    int'(hz_bus.hz_state),    m_phase);
        chk("stall_count", int'(hz_bus.stall_count), m_stalls);
        chk("mem_timeout", int'(hz_bus.mem_timeout), int'(m_tout));

        if (!reset_n) begin
            n_phase = 0; n_stalls = 0; n_waited = 0; n_tout = 0;
        end else begin
            n_stalls = (stall && m_stalls < CNT_MAX) ? m_stalls + 1 : m_stalls;
            n_tout   = m_tout;
            if (m_phase == 2) begin
                n_waited = m_waited + 1;
                if (n_waited >= WAIT_MAX) n_tout = 1;
            end else begin
                n_waited = 0;
            end
            case (m_phase)
                0:       n_phase = ms ? 2 : ((lu || fh) ? 1 : 0);
                1:       n_phase = ms ? 2 : 0;
                default: n_phase = hz_bus.dmem_ready ? 0 : 2;
            endcase
        end
    end

    // Commit model state on the active edge
    always @(posedge clk) begin
        m_phase  = n_phase;
        m_stalls = n_stalls;
        m_waited = n_waited;
        m_tout   = n_tout;
    end

    task automatic clr_in();
        hz_bus.id_rd_sw        = '0;
        hz_bus.id_lw_sw_sel    = '0;
        hz_bus.id_add_sel      = '0;
        hz_bus.id_sub_rm_sel   = '0;
        hz_bus.id_sub_rn_sel   = '0;
        hz_bus.id_cmp_shft_rd  = '0;
        hz_bus.id_use          = '0;
        hz_bus.id_flagRead     = 1'b0;
        hz_bus.IDEX_memRead1   = 1'b0;
        hz_bus.IDEX_regWrite1  = 1'b0;
        hz_bus.IDEX_flagWrite1 = 1'b0;
        hz_bus.IDEX_rd1        = '0;
        hz_bus.dmem_req        = 1'b0;
        hz_bus.dmem_ready      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        clr_in();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        m_phase = 0; m_stalls = 0; m_waited = 0; m_tout = 0;
        n_phase = 0; n_stalls = 0; n_waited = 0; n_tout = 0;
        reset_n = 1'b0;
        clr_in();
        @(negedge clk);
        chk("rst_state",   int'(hz_bus.hz_state),    0);
        chk("rst_count",   int'(hz_bus.stall_count), 0);
        chk("rst_pcwrite", int'(hz_bus.PCwrite),     1);
        tick();
        reset_n = 1'b1;

        // Load-use on id_add_sel: one bubble, one LU_STALL cycle, back to RUN
        do_reset();
        hz_bus.IDEX_memRead1 = 1; hz_bus.IDEX_regWrite1 = 1; hz_bus.IDEX_rd1 = 3'd3;
        hz_bus.id_add_sel = 3'd3; hz_bus.id_use = 6'b000100;
        @(negedge clk);
        chk("lu_pcwrite", int'(hz_bus.PCwrite),   0);
        chk("lu_flush",   int'(hz_bus.IDEX_flush), 1);
        tick();
        hz_bus.IDEX_memRead1 = 0; hz_bus.IDEX_regWrite1 = 0;
        @(negedge clk);
        chk("lu_state1",  int'(hz_bus.hz_state), 1);
        chk("lu_release", int'(hz_bus.PCwrite),  1);
        tick();
        @(negedge clk);
        chk("lu_state0",  int'(hz_bus.hz_state),    0);
        chk("lu_count",   int'(hz_bus.stall_count), 1);

        // Same match but source not read: no stall
        do_reset();
        hz_bus.IDEX_memRead1 = 1; hz_bus.IDEX_regWrite1 = 1; hz_bus.IDEX_rd1 = 3'd3;
        hz_bus.id_add_sel = 3'd3; hz_bus.id_use = 6'b000000;
        @(negedge clk);
        chk("unused_pcwrite", int'(hz_bus.PCwrite), 1);
        tick();
        @(negedge clk);
        chk("unused_count", int'(hz_bus.stall_count), 0);

        // Flag hazard: one bubble
        do_reset();
        hz_bus.IDEX_flagWrite1 = 1; hz_bus.id_flagRead = 1;
        @(negedge clk);
        chk("flag_flush", int'(hz_bus.IDEX_flush), 1);
        tick();
        hz_bus.IDEX_flagWrite1 = 0;
        @(negedge clk);
        chk("flag_state", int'(hz_bus.hz_state), 1);
        tick();
        @(negedge clk);
        chk("flag_count", int'(hz_bus.stall_count), 1);

        // Memory wait: ready low for 3 cycles, release on the ready cycle
        do_reset();
        hz_bus.dmem_req = 1; hz_bus.dmem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mw_hold", int'(hz_bus.EXMEM_hold), 1);
            tick();
        end
        hz_bus.dmem_ready = 1;
        @(negedge clk);
        chk("mw_release_hold", int'(hz_bus.EXMEM_hold), 0);
        chk("mw_release_pc",   int'(hz_bus.PCwrite),    1);
        tick();
        hz_bus.dmem_req = 0; hz_bus.dmem_ready = 0;
        @(negedge clk);
        chk("mw_state", int'(hz_bus.hz_state),    0);
        chk("mw_count", int'(hz_bus.stall_count), 3);

        // Memory stall and load-use together, 5-cycle wait with WAIT_MAX=2
        do_reset();
        hz_bus.dmem_req = 1; hz_bus.dmem_ready = 0;
        hz_bus.IDEX_memRead1 = 1; hz_bus.IDEX_regWrite1 = 1; hz_bus.IDEX_rd1 = 3'd5;
        hz_bus.id_cmp_shft_rd = 3'd5; hz_bus.id_use = 6'b100000;
        @(negedge clk);
        chk("both_hold",  int'(hz_bus.EXMEM_hold), 1);
        chk("both_flush", int'(hz_bus.IDEX_flush), 0);
        for (int k = 2; k <= 5; k++) begin
            tick();
            @(negedge clk);
            if (k == 4) chk("both_timeout", int'(hz_bus.mem_timeout), 1);
        end
        tick();
        hz_bus.dmem_ready = 1;
        @(negedge clk);
        chk("both_ready_state", int'(hz_bus.hz_state), 2);
        tick();
        hz_bus.dmem_req = 0; hz_bus.dmem_ready = 0;
        @(negedge clk);
        chk("both_lu_flush", int'(hz_bus.IDEX_flush), 1);
        tick();
        hz_bus.IDEX_memRead1 = 0; hz_bus.IDEX_regWrite1 = 0;
        @(negedge clk);
        chk("both_lu_state", int'(hz_bus.hz_state), 1);
        tick();
        @(negedge clk);
        chk("both_count",  int'(hz_bus.stall_count), 6);
        chk("both_sticky", int'(hz_bus.mem_timeout), 1);

        // Reset asserted in the middle of a memory wait
        do_reset();
        hz_bus.dmem_req = 1; hz_bus.dmem_ready = 0;
        repeat (3) tick();
        #2 reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_state",   int'(hz_bus.hz_state),    0);
        chk("midrst_count",   int'(hz_bus.stall_count), 0);
        chk("midrst_timeout", int'(hz_bus.mem_timeout), 0);
        chk("midrst_hold",    int'(hz_bus.EXMEM_hold),  0);
        chk("midrst_pc",      int'(hz_bus.PCwrite),     1);
        tick();
        reset_n = 1'b1;
        clr_in();

        // Long wait drives stall_count into saturation
        do_reset();
        hz_bus.dmem_req = 1; hz_bus.dmem_ready = 0;
        repeat (20) tick();
        @(negedge clk);
        chk("sat_count", int'(hz_bus.stall_count), CNT_MAX);
        tick();
        clr_in();

        // Randomized traffic, small register range so matches are frequent
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset_n                = ($urandom_range(0, 149) != 0);
            hz_bus.id_rd_sw        = 3'($urandom_range(0, 3));
            hz_bus.id_lw_sw_sel    = 3'($urandom_range(0, 3));
            hz_bus.id_add_sel      = 3'($urandom_range(0, 3));
            hz_bus.id_sub_rm_sel   = 3'($urandom_range(0, 3));
            hz_bus.id_sub_rn_sel   = 3'($urandom_range(0, 3));
            hz_bus.id_cmp_shft_rd  = 3'($urandom_range(0, 3));
            hz_bus.id_use          = 6'($urandom);
            hz_bus.id_flagRead     = 1'($urandom_range(0, 1));
            hz_bus.IDEX_memRead1   = 1'($urandom_range(0, 1));
            hz_bus.IDEX_regWrite1  = 1'($urandom_range(0, 1));
            hz_bus.IDEX_flagWrite1 = ($urandom_range(0, 3) == 0);
            hz_bus.IDEX_rd1        = 3'($urandom_range(0, 3));
            hz_bus.dmem_req        = ($urandom_range(0, 2) == 0);
            hz_bus.dmem_ready      = 1'($urandom_range(0, 1));
            tick();
        end
        reset_n = 1'b1;
        clr_in();
        tick();
        @(negedge clk);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
